// File: rtl/dcsformer_driver.sv
// Streaming initiator for the DCSformer sparse-attention core: holds the input matrix
// and weight vector, streams them to the core, and collects the result words.
module dcsformer_driver #(
    parameter int ROWS    = 8,
    parameter int COLS    = 16,
    parameter int DW      = 8,
    parameter int OW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [7:0]              cfg_addr,
    input  logic [DW-1:0]           cfg_wdata,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [$clog2(ROWS)-1:0] res_idx,
    output logic [OW-1:0]           res_data,
    output logic                    i_valid,
    output logic [DW-1:0]           i_data,
    output logic                    w_valid,
    output logic [DW-1:0]           w_data,
    input  logic                    w_ready,
    input  logic                    o_valid,
    input  logic [OW-1:0]           o_data
);

    localparam int NMAT = ROWS * COLS;
    localparam int BW   = $clog2(NMAT);
    localparam int RW   = $clog2(ROWS);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [8:0]    MAT_END   = 9'(NMAT);
    localparam logic [8:0]    W_END     = 9'(NMAT + ROWS);
    localparam logic [BW-1:0] BEAT_LAST = BW'(NMAT - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEND_I = 3'd1;
    localparam logic [2:0] ST_WAIT_W = 3'd2;
    localparam logic [2:0] ST_SEND_W = 3'd3;
    localparam logic [2:0] ST_RECV   = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;
    localparam logic [2:0] ST_ABORT  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] res_n_q, res_n_d;
    logic          w_pend_q, w_pend_d;
    logic          err_q, err_d;

    logic [DW-1:0] matrix_q [NMAT];
    logic [DW-1:0] matrix_d [NMAT];
    logic [DW-1:0] weight_q [ROWS];
    logic [DW-1:0] weight_d [ROWS];
    logic [OW-1:0] result_q [ROWS];
    logic [OW-1:0] result_d [ROWS];

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          i_valid_q, i_valid_d;
    logic [DW-1:0] i_data_q, i_data_d;
    logic          w_valid_q, w_valid_d;
    logic [DW-1:0] w_data_q, w_data_d;

    logic [RW-1:0] w_sel;
    assign w_sel = RW'(cfg_addr - 8'(NMAT));

    // NOTE: every variable gets a default at the top of the block so no path leaves
    // it unassigned; a missing default in always_comb infers a latch.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        res_n_d  = res_n_q;
        w_pend_d = w_pend_q;
        err_d    = err_q;
        matrix_d = matrix_q;
        weight_d = weight_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                // The write is folded in before start so a same-cycle start sees the new byte.
                if (cfg_we) begin
                    if ({1'b0, cfg_addr} < MAT_END) begin
                        matrix_d[cfg_addr[BW-1:0]] = cfg_wdata;
                    end else if ({1'b0, cfg_addr} < W_END) begin
                        weight_d[w_sel] = cfg_wdata;
                    end
                end
                if (start) begin
                    state_d  = ST_SEND_I;
                    beat_d   = '0;
                    tmo_d    = '0;
                    res_n_d  = '0;
                    w_pend_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            ST_SEND_I: begin
                if (w_ready) begin
                    w_pend_d = 1'b1;
                end
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_WAIT_W;
                    beat_d  = '0;
                    tmo_d   = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_WAIT_W: begin
                if (w_ready || w_pend_q) begin
                    state_d  = ST_SEND_W;
                    w_pend_d = 1'b0;
                end else if (tmo_q >= TMO_MAX) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_SEND_W: begin
                if (beat_q[RW-1:0] == ROW_LAST) begin
                    state_d = ST_RECV;
                    beat_d  = '0;
                    tmo_d   = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_RECV: begin
                if (o_valid) begin
                    result_d[res_n_q] = o_data;
                    tmo_d             = '0;
                    if (res_n_q == ROW_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        res_n_d = res_n_q + RW'(1);
                    end
                end else if (tmo_q >= TMO_MAX) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_FIN, ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stream outputs are computed from the next state so they leave a flop aligned with it.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_FIN) || (state_d == ST_ABORT);
        i_valid_d = (state_d == ST_SEND_I);
        i_data_d  = i_valid_d ? matrix_d[beat_d] : '0;
        w_valid_d = (state_d == ST_SEND_W);
        w_data_d  = w_valid_d ? weight_d[beat_d[RW-1:0]] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            tmo_q     <= '0;
            res_n_q   <= '0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            i_valid_q <= 1'b0;
            i_data_q  <= '0;
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            res_n_q   <= res_n_d;
            w_pend_q  <= w_pend_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            i_valid_q <= i_valid_d;
            i_data_q  <= i_data_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
        end
    end

    // NOTE: the buffers are flop arrays with a reset because their contents are
    // observable (streamed or read back) right after reset and must read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrix_q <= '{default: '0};
            weight_q <= '{default: '0};
            result_q <= '{default: '0};
        end else begin
            matrix_q <= matrix_d;
            weight_q <= weight_d;
            result_q <= result_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign i_valid  = i_valid_q;
    assign i_data   = i_data_q;
    assign w_valid  = w_valid_q;
    assign w_data   = w_data_q;
    assign res_data = result_q[res_idx];

endmodule

// File: tb/tb_dcsformer_driver.sv
// Self-checking bench for dcsformer_driver: a behavioural core responder plus a
// golden sparse-attention model derived from the loaded matrix and weights.
module tb_dcsformer_driver;

    localparam int TMO = 15;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  res_idx;
    logic [31:0] res_data;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        w_ready;
    logic        o_valid;
    logic [31:0] o_data;

    dcsformer_driver #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .busy(busy), .done(done), .err(err),
        .res_idx(res_idx), .res_data(res_data),
        .i_valid(i_valid), .i_data(i_data),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .o_valid(o_valid), .o_data(o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_mat [128];
    logic [7:0]  m_w   [8];
    logic [31:0] exp_res [8];

    logic [7:0]  got_i [$];
    logic [7:0]  got_w [$];
    logic [31:0] sent  [$];
    int done_cyc, done_cnt, last_cap_cyc, first_i_cyc, first_w_cyc, overlap, i_bad, w_bad;
    logic err_at_done, rst_iv, rst_busy;

    // Golden core: S = A*A^T, keep S[j][i] where it reaches the row mean, weight and sum.
    function automatic logic [31:0] core_ref(input logic [7:0] m[128], input logic [7:0] wv[8], input int j);
        longint s[8];
        longint tot = 0;
        longint acc = 0;
        for (int i = 0; i < 8; i++) begin
            s[i] = 0;
            for (int c = 0; c < 16; c++) s[i] += longint'(m[j*16+c]) * longint'(m[i*16+c]);
            tot += s[i];
        end
        for (int i = 0; i < 8; i++) if (s[i] * 8 >= tot) acc += s[i] * longint'(wv[i]);
        return acc[31:0];
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (a < 8'd128) m_mat[a[6:0]] = d;
        else if (a < 8'd136) m_w[a[2:0]] = d;
    endtask

    // One transaction, cycle by cycle from the negedge: observe outputs, then drive the core side.
    // Cycle 1 is the first cycle after start is sampled. mode: 0 golden, 1 values 1..n, 2 random.
    task automatic run_txn(input int rdy_cyc, input int gap, input int mode, input int n_words,
                           input int rst_cyc, input int busy_cyc);
        logic [31:0] words [$];
        logic [7:0]  ri [128];
        logic [7:0]  rw [8];
        int next_o;
        got_i.delete(); got_w.delete(); sent.delete();
        done_cyc = -1; done_cnt = 0; last_cap_cyc = -1; first_i_cyc = -1; first_w_cyc = -1;
        overlap = 0; err_at_done = 1'bx; next_o = -1; rst_iv = 1'bx; rst_busy = 1'bx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (i_valid) begin
                if (first_i_cyc < 0) first_i_cyc = cyc;
                got_i.push_back(i_data);
            end
            if (w_valid) begin
                if (first_w_cyc < 0) first_w_cyc = cyc;
                got_w.push_back(w_data);
                if (got_w.size() == 8) begin
                    for (int k = 0; k < 128; k++) ri[k] = (k < got_i.size()) ? got_i[k] : 8'h00;
                    for (int k = 0; k < 8; k++) rw[k] = got_w[k];
                    for (int k = 0; k < n_words; k++) begin
                        if (mode == 0 && k < 8) words.push_back(core_ref(ri, rw, k));
                        else if (mode == 1) words.push_back(32'(k + 1));
                        else words.push_back($urandom);
                    end
                    next_o = cyc + 1;
                end
            end
            if (i_valid && w_valid) overlap++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; err_at_done = err; end
            end
            w_ready = (cyc == rdy_cyc);
            o_valid = 1'b0;
            o_data  = $urandom;
            if (cyc == 3) begin o_valid = 1'b1; o_data = 32'hdead_beef; end
            if (next_o >= 0 && cyc == next_o && sent.size() < words.size()) begin
                o_valid = 1'b1;
                o_data  = words[sent.size()];
                sent.push_back(o_data);
                if (sent.size() == 8) last_cap_cyc = cyc;
                next_o = cyc + 1 + gap;
            end
            if (cyc == busy_cyc) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = ~m_mat[0];
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                rst_iv = i_valid; rst_busy = busy;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 20) break;
            @(negedge clk);
        end
        w_ready = 1'b0; o_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
        i_bad = 0;
        for (int k = 0; k < got_i.size(); k++) if (got_i[k] !== m_mat[k]) i_bad++;
        w_bad = 0;
        for (int k = 0; k < got_w.size(); k++) if (got_w[k] !== m_w[k]) w_bad++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({busy, done, err, i_valid, w_valid, i_data, w_data} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, done, err, i_valid, w_valid, i_data, w_data});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=000", {busy, done, err});
        end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== 32'd0) begin
                failures++; $display("FAIL reset_res[%0d] got=%0d exp=0", k, res_data);
            end
        end
        for (int k = 0; k < 128; k++) m_mat[k] = 8'h00;
        for (int k = 0; k < 8; k++) m_w[k] = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_all_ones;
        for (int k = 0; k < 136; k++) cfg_write(8'(k), 8'd1);
        run_txn(131, 0, 0, 8, -1, -1);
        checks++;
        if (got_i.size() !== 128 || i_bad !== 0 || first_i_cyc !== 1) begin
            failures++; $display("FAIL ones_i_stream beats=%0d bad=%0d first=%0d exp=128/0/1", got_i.size(), i_bad, first_i_cyc);
        end
        checks++;
        if (got_w.size() !== 8 || w_bad !== 0 || first_w_cyc !== 132) begin
            failures++; $display("FAIL ones_w_stream beats=%0d bad=%0d first=%0d exp=8/0/132", got_w.size(), w_bad, first_w_cyc);
        end
        checks++;
        if (overlap !== 0) begin failures++; $display("FAIL ones_overlap got=%0d exp=0", overlap); end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_cap_cyc + 1 || last_cap_cyc < 0) begin
            failures++; $display("FAIL ones_done cnt=%0d cyc=%0d last_cap=%0d", done_cnt, done_cyc, last_cap_cyc);
        end
        checks++;
        if (err_at_done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL ones_err got=%b exp=0", err_at_done); end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== 32'd128) begin failures++; $display("FAIL ones_res[%0d] got=%0d exp=128", k, res_data); end
        end
        @(negedge clk);
    endtask

    // w_ready pulsed during SEND_I must be honoured on entering WAIT_W.
    task automatic test_row_ramp;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) cfg_write(8'(r*16 + c), 8'(r + 1));
        for (int k = 0; k < 8; k++) cfg_write(8'(128 + k), 8'd1);
        for (int k = 0; k < 8; k++) exp_res[k] = core_ref(m_mat, m_w, k);
        run_txn(60, 0, 0, 8, -1, -1);
        checks++;
        if (got_i.size() !== 128 || i_bad !== 0) begin
            failures++; $display("FAIL ramp_i_stream beats=%0d bad=%0d exp=128/0", got_i.size(), i_bad);
        end
        checks++;
        if (got_w.size() !== 8 || w_bad !== 0 || first_w_cyc !== 130) begin
            failures++; $display("FAIL ramp_early_ready beats=%0d bad=%0d first=%0d exp=8/0/130", got_w.size(), w_bad, first_w_cyc);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_cap_cyc + 1 || err_at_done !== 1'b0) begin
            failures++; $display("FAIL ramp_done cnt=%0d cyc=%0d last_cap=%0d err=%b", done_cnt, done_cyc, last_cap_cyc, err_at_done);
        end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== exp_res[k]) begin failures++; $display("FAIL ramp_res[%0d] got=%0d exp=%0d", k, res_data, exp_res[k]); end
        end
        @(negedge clk);
    endtask

    // Random data, ignored high addresses, gapped results and two surplus words.
    task automatic test_gaps;
        for (int k = 0; k < 136; k++) cfg_write(8'(k), 8'($urandom));
        for (int k = 0; k < 6; k++) cfg_write(8'($urandom_range(136, 255)), 8'($urandom));
        run_txn(129, 1, 1, 10, -1, -1);
        checks++;
        if (got_i.size() !== 128 || i_bad !== 0) begin
            failures++; $display("FAIL gaps_i_stream beats=%0d bad=%0d exp=128/0", got_i.size(), i_bad);
        end
        checks++;
        if (got_w.size() !== 8 || w_bad !== 0 || first_w_cyc !== 130) begin
            failures++; $display("FAIL gaps_w_stream beats=%0d bad=%0d first=%0d exp=8/0/130", got_w.size(), w_bad, first_w_cyc);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_cap_cyc + 1 || last_cap_cyc < 0) begin
            failures++; $display("FAIL gaps_done cnt=%0d cyc=%0d last_cap=%0d", done_cnt, done_cyc, last_cap_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== 32'(k + 1)) begin failures++; $display("FAIL gaps_res[%0d] got=%0d exp=%0d", k, res_data, k + 1); end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        run_txn(-1, 0, 2, 8, -1, -1);
        checks++;
        if (done_cyc !== 145 || done_cnt !== 1) begin
            failures++; $display("FAIL tmo_done cyc=%0d cnt=%0d exp=145/1", done_cyc, done_cnt);
        end
        checks++;
        if (err_at_done !== 1'b1 || err !== 1'b1) begin
            failures++; $display("FAIL tmo_err at_done=%b now=%b exp=1/1", err_at_done, err);
        end
        checks++;
        if (got_w.size() !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL tmo_no_w beats=%0d busy=%b exp=0/0", got_w.size(), busy);
        end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== 32'(k + 1)) begin failures++; $display("FAIL tmo_kept_res[%0d] got=%0d exp=%0d", k, res_data, k + 1); end
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        run_txn(140, 0, 2, 8, -1, 20);
        for (int k = 0; k < 8; k++) exp_res[k] = (k < sent.size()) ? sent[k] : 32'hx;
        checks++;
        if (got_i.size() !== 128 || i_bad !== 0) begin
            failures++; $display("FAIL busy_i_stream beats=%0d bad=%0d exp=128/0", got_i.size(), i_bad);
        end
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b0 || first_w_cyc !== 141) begin
            failures++; $display("FAIL busy_txn done=%0d err=%b first_w=%0d exp=1/0/141", done_cnt, err_at_done, first_w_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== exp_res[k]) begin failures++; $display("FAIL busy_res[%0d] got=%0d exp=%0d", k, res_data, exp_res[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        run_txn(-1, 0, 2, 8, 51, -1);
        checks++;
        if (rst_iv !== 1'b0 || rst_busy !== 1'b0) begin
            failures++; $display("FAIL rst_async i_valid=%b busy=%b exp=0/0", rst_iv, rst_busy);
        end
        checks++;
        if (got_i.size() !== 51 || i_bad !== 0) begin
            failures++; $display("FAIL rst_prefix beats=%0d bad=%0d exp=51/0", got_i.size(), i_bad);
        end
        for (int k = 0; k < 128; k++) m_mat[k] = 8'h00;
        for (int k = 0; k < 8; k++) m_w[k] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== 32'd0) begin failures++; $display("FAIL rst_res_clear[%0d] got=%0d exp=0", k, res_data); end
        end
        @(negedge clk);
        cfg_write(8'd0, 8'($urandom_range(1, 255)));
        cfg_write(8'd37, 8'($urandom_range(1, 255)));
        for (int k = 0; k < 8; k++) cfg_write(8'(128 + k), 8'($urandom_range(1, 255)));
        for (int k = 0; k < 8; k++) exp_res[k] = core_ref(m_mat, m_w, k);
        run_txn(135, 2, 0, 8, -1, -1);
        checks++;
        if (got_i.size() !== 128 || i_bad !== 0 || got_i.size() == 0 || got_i[0] !== m_mat[0]) begin
            failures++; $display("FAIL rst_restart_i beats=%0d bad=%0d exp=128/0", got_i.size(), i_bad);
        end
        checks++;
        if (got_w.size() !== 8 || w_bad !== 0 || done_cnt !== 1 || done_cyc !== last_cap_cyc + 1 || err_at_done !== 1'b0) begin
            failures++; $display("FAIL rst_restart_txn w=%0d bad=%0d done=%0d cyc=%0d last=%0d", got_w.size(), w_bad, done_cnt, done_cyc, last_cap_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            res_idx = 3'(k); #1;
            checks++;
            if (res_data !== exp_res[k]) begin failures++; $display("FAIL rst_restart_res[%0d] got=%0d exp=%0d", k, res_data, exp_res[k]); end
        end
        @(negedge clk);
    endtask

    initial begin
        cfg_we = 1'b0; cfg_addr = 8'd0; cfg_wdata = 8'd0; start = 1'b0;
        res_idx = 3'd0; w_ready = 1'b0; o_valid = 1'b0; o_data = 32'd0;
        test_reset();
        test_all_ones();
        test_row_ramp();
        test_gaps();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
